// File: rtl/mmtiled_tile_scheduler.sv
// mmtiled_tile_scheduler
// Purpose : walks the (ii, jj, kk) tile loop nest of an N x N tiled matrix
//           multiply, buffers the tile jobs in a small FIFO and hands them out
//           one per grant to NUM_REQ tile engines through a round-robin arbiter.
// Latency : start accepted at t -> SETUP at t+1 -> first push at t+2 ->
//           first tile on the outputs at t+4; req sampled at t -> grant at t+1.
// Backpressure: the generator stalls while the registered FIFO count is full;
//           requesters are served only while jobs are buffered; enabled_in low
//           freezes everything and suppresses grants.
//
// Ports:
//   clock, rst_in (sync, active-high), enabled_in, start_in
//   size_n_in / tile_size_in : problem and tile edge, sampled on accepted start
//   req_in / grant_out       : per-engine request level and one-hot grant
//   tile_valid_out, tile_ii_out, tile_jj_out, tile_kk_out, tile_last_out
//   busy_out, done_out, tile_count_out
//
// Build option: define MMTILED_TILE_SCHED_STATS_EN to build the saturating
// granted-tile counter on tile_count_out; otherwise tile_count_out is 0.

module mmtiled_tile_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clock,
    input  logic               rst_in,
    input  logic               enabled_in,
    input  logic               start_in,
    input  logic [31:0]        size_n_in,
    input  logic [31:0]        tile_size_in,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic               tile_valid_out,
    output logic [31:0]        tile_ii_out,
    output logic [31:0]        tile_jj_out,
    output logic [31:0]        tile_kk_out,
    output logic               tile_last_out,
    output logic               busy_out,
    output logic               done_out,
    output logic [31:0]        tile_count_out
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int EW = 97;  // {ii, jj, kk, last}

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_GEN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [31:0]        size_q;
    logic [31:0]        tile_q;
    logic [31:0]        ii_q;
    logic [31:0]        jj_q;
    logic [31:0]        kk_q;

    logic [EW-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [PW-1:0]      rr_q;

    logic [NUM_REQ-1:0] grant_q;
    logic               valid_q;
    logic [31:0]        out_ii_q;
    logic [31:0]        out_jj_q;
    logic [31:0]        out_kk_q;
    logic               out_last_q;
    logic               busy_q;
    logic               done_q;

    // ------------------------------------------------------------------
    // Loop-nest stepping. Sums are 33 bits so a tile that lands past the
    // end of a near-2^32 matrix still reads as a wrap instead of overflowing.
    // ------------------------------------------------------------------
    logic [32:0] kk_nxt;
    logic [32:0] jj_nxt;
    logic [32:0] ii_nxt;
    logic        kk_wrap;
    logic        jj_wrap;
    logic        ii_wrap;
    logic        final_pos;

    assign kk_nxt    = {1'b0, kk_q} + {1'b0, tile_q};
    assign jj_nxt    = {1'b0, jj_q} + {1'b0, tile_q};
    assign ii_nxt    = {1'b0, ii_q} + {1'b0, tile_q};
    assign kk_wrap   = (kk_nxt >= {1'b0, size_q});
    assign jj_wrap   = (jj_nxt >= {1'b0, size_q});
    assign ii_wrap   = (ii_nxt >= {1'b0, size_q});
    assign final_pos = kk_wrap & jj_wrap & ii_wrap;

    // ------------------------------------------------------------------
    // FIFO control. Full is judged on the registered count, so a push is
    // refused when full even if a pop frees a slot in the same cycle.
    // ------------------------------------------------------------------
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [EW-1:0] head;

    assign fifo_empty = (count_q == '0);
    assign push       = enabled_in && (state_q == S_GEN) && (count_q < CW'(FIFO_DEPTH));
    assign pop        = enabled_in && !fifo_empty && (|req_in);
    assign head       = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Round-robin pick: first requester at or after the rr pointer.
    // ------------------------------------------------------------------
    logic [PW-1:0]      gnt_idx;
    logic               gnt_found;
    logic [PW-1:0]      rr_nxt;
    logic [NUM_REQ-1:0] grant_vec;

    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_in[(int'(rr_q) + i) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'((int'(rr_q) + i) % NUM_REQ);
            end
        end
    end

    assign rr_nxt    = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
    assign grant_vec = NUM_REQ'(1) << gnt_idx;

    // Job storage has no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ii_q, jj_q, kk_q, kk_wrap};
        end
    end

    // ------------------------------------------------------------------
    // FSM, FIFO bookkeeping and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            size_q     <= '0;
            tile_q     <= '0;
            ii_q       <= '0;
            jj_q       <= '0;
            kk_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_q       <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            out_ii_q   <= '0;
            out_jj_q   <= '0;
            out_kk_q   <= '0;
            out_last_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Grant outputs are single-cycle strobes.
            valid_q <= 1'b0;
            grant_q <= '0;

            if (enabled_in) begin
                done_q <= 1'b0;

                case (state_q)
                    S_IDLE: begin
                        if (start_in) begin
                            size_q <= size_n_in;
                            tile_q <= tile_size_in;
                            if ((size_n_in == '0) || (tile_size_in == '0)) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_SETUP;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    S_SETUP: begin
                        ii_q    <= '0;
                        jj_q    <= '0;
                        kk_q    <= '0;
                        state_q <= S_GEN;
                    end
                    S_GEN: begin
                        if (push) begin
                            if (kk_wrap) begin
                                kk_q <= '0;
                                if (jj_wrap) begin
                                    jj_q <= '0;
                                    ii_q <= ii_nxt[31:0];
                                end else begin
                                    jj_q <= jj_nxt[31:0];
                                end
                            end else begin
                                kk_q <= kk_nxt[31:0];
                            end
                            if (final_pos) begin
                                state_q <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        // The last pop's tile is already in the output register.
                        if (fifo_empty) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase

                if (state_q == S_SETUP) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                    end
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                    end
                    count_q <= count_q + CW'(push) - CW'(pop);
                end

                if (pop) begin
                    grant_q    <= grant_vec;
                    valid_q    <= 1'b1;
                    out_ii_q   <= head[96:65];
                    out_jj_q   <= head[64:33];
                    out_kk_q   <= head[32:1];
                    out_last_q <= head[0];
                    rr_q       <= rr_nxt;
                end
            end
        end
    end

    assign grant_out      = grant_q;
    assign tile_valid_out = valid_q;
    assign tile_ii_out    = out_ii_q;
    assign tile_jj_out    = out_jj_q;
    assign tile_kk_out    = out_kk_q;
    assign tile_last_out  = out_last_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;

`ifdef MMTILED_TILE_SCHED_STATS_EN
    logic [31:0] tile_cnt_q;

    always_ff @(posedge clock) begin
        if (rst_in) begin
            tile_cnt_q <= '0;
        end else if (enabled_in) begin
            if ((state_q == S_IDLE) && start_in) begin
                tile_cnt_q <= '0;
            end else if (pop && (tile_cnt_q != '1)) begin
                tile_cnt_q <= tile_cnt_q + 32'd1;
            end
        end
    end

    assign tile_count_out = tile_cnt_q;
`else
    assign tile_count_out = '0;
`endif

endmodule

// File: tb/tb_mmtiled_tile_scheduler.sv
// Directed bench for mmtiled_tile_scheduler: a table of tile jobs is run
// against a loop-nest / round-robin reference, plus a reset-mid-job sequence.
module tb_mmtiled_tile_scheduler;

    logic        clock = 1'b0;
    logic        rst_in = 1'b1;
    logic        enabled_in = 1'b1;
    logic        start_in = 1'b0;
    logic [31:0] size_n_in = '0;
    logic [31:0] tile_size_in = '0;
    logic [3:0]  req_in = '0;
    logic [3:0]  grant_out;
    logic        tile_valid_out;
    logic [31:0] tile_ii_out;
    logic [31:0] tile_jj_out;
    logic [31:0] tile_kk_out;
    logic        tile_last_out;
    logic        busy_out;
    logic        done_out;
    logic [31:0] tile_count_out;

    int checks = 0;
    int failures = 0;

    localparam int BUDGET = 600;

    mmtiled_tile_scheduler #(.NUM_REQ(4), .FIFO_DEPTH(16)) dut (
        .clock         (clock),
        .rst_in        (rst_in),
        .enabled_in    (enabled_in),
        .start_in      (start_in),
        .size_n_in     (size_n_in),
        .tile_size_in  (tile_size_in),
        .req_in        (req_in),
        .grant_out     (grant_out),
        .tile_valid_out(tile_valid_out),
        .tile_ii_out   (tile_ii_out),
        .tile_jj_out   (tile_jj_out),
        .tile_kk_out   (tile_kk_out),
        .tile_last_out (tile_last_out),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .tile_count_out(tile_count_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         sz;
        int         tl;
        logic [3:0] rq;
        int         exp_tiles;
        int         exp_lasts;
        int         stall;     // cycles req_in is held at 0 after start
        int         en_from;   // enabled_in low from this cycle...
        int         en_len;    // ...for this many cycles (0 = never)
        bit         poke;      // extra start pulse while the job runs
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // First requester at or after p, or -1.
    function automatic int pick(input int p, input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string name);
        chk(!tile_valid_out && !tile_last_out && !busy_out && !done_out &&
            grant_out == 4'b0 && tile_ii_out == 0 && tile_jj_out == 0 &&
            tile_kk_out == 0 && tile_count_out == 0, name,
            $sformatf("got v=%0b l=%0b b=%0b d=%0b g=%b ii=%0d jj=%0d kk=%0d cnt=%0d, want all 0",
                      tile_valid_out, tile_last_out, busy_out, done_out, grant_out,
                      tile_ii_out, tile_jj_out, tile_kk_out, tile_count_out));
    endtask

    task automatic do_reset();
        rst_in     = 1'b1;
        enabled_in = 1'b1;
        start_in   = 1'b0;
        req_in     = 4'b0;
        repeat (2) step();
        check_reset_outputs("reset_state");
        rst_in = 1'b0;
    endtask

    task automatic run_job(input vec_t v, input string tag);
        logic [96:0] expq[$];
        logic [96:0] e;
        logic [96:0] act;
        logic [3:0]  one = 4'b0001;
        logic [3:0]  eg;
        int ptr = 0;
        int n_tiles = 0, n_lasts = 0, done_cnt = 0, done_cyc = -1, first_cyc = -1;
        int extras = 0, stray = 0, stall_viol = 0, en_viol = 0, idx;
        int exp_cnt;

        if (v.sz > 0 && v.tl > 0) begin
            for (int ii = 0; ii < v.sz; ii += v.tl)
                for (int jj = 0; jj < v.sz; jj += v.tl)
                    for (int kk = 0; kk < v.sz; kk += v.tl)
                        expq.push_back({32'(ii), 32'(jj), 32'(kk), (kk + v.tl >= v.sz)});
        end

        size_n_in    = 32'(v.sz);
        tile_size_in = 32'(v.tl);
        req_in       = (v.stall == 0) ? v.rq : 4'b0;
        enabled_in   = 1'b1;
        start_in     = 1'b1;

        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            step();
            if (tile_valid_out) begin
                n_tiles++;
                if (first_cyc < 0) first_cyc = cyc;
                if (tile_last_out) n_lasts++;
                if (expq.size() == 0) begin
                    extras++;
                end else begin
                    e   = expq.pop_front();
                    idx = pick(ptr, v.rq);
                    eg  = (idx >= 0) ? (one << idx) : 4'b0;
                    ptr = (idx + 1) % 4;
                    act = {tile_ii_out, tile_jj_out, tile_kk_out, tile_last_out};
                    chk(act == e && grant_out == eg, {tag, "_tile"},
                        $sformatf("#%0d got (%0d,%0d,%0d) last=%0b g=%b, want (%0d,%0d,%0d) last=%0b g=%b",
                                  n_tiles, act[96:65], act[64:33], act[32:1], act[0], grant_out,
                                  e[96:65], e[64:33], e[32:1], e[0], eg));
                end
            end else if (grant_out != 4'b0) begin
                stray++;
            end
            if (cyc <= v.stall && tile_valid_out) stall_viol++;
            if (v.en_len > 0 && cyc > v.en_from && cyc <= v.en_from + v.en_len &&
                (tile_valid_out || grant_out != 4'b0)) en_viol++;
            if (cyc == 1 && v.sz != 0 && v.tl != 0)
                chk(busy_out == 1'b1, {tag, "_busy_rise"}, $sformatf("busy=%0b want 1", busy_out));
            if (done_out) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    chk(busy_out == 1'b0, {tag, "_busy_fall"},
                        $sformatf("busy=%0b with done, want 0", busy_out));
                end
            end
            if (done_cnt > 0 && cyc >= done_cyc + 5) break;

            start_in   = v.poke && (cyc == 10);
            size_n_in  = (v.poke && cyc == 10) ? 32'd16 : 32'(v.sz);
            req_in     = (cyc >= v.stall) ? v.rq : 4'b0;
            enabled_in = !(v.en_len > 0 && cyc >= v.en_from && cyc < v.en_from + v.en_len);
        end
        start_in   = 1'b0;
        enabled_in = 1'b1;

        chk(done_cnt == 1, {tag, "_done_once"},
            $sformatf("done pulses=%0d want 1 (0 means timeout)", done_cnt));
        chk(n_tiles == v.exp_tiles && extras == 0, {tag, "_tiles"},
            $sformatf("tiles=%0d extra=%0d want %0d", n_tiles, extras, v.exp_tiles));
        chk(n_lasts == v.exp_lasts, {tag, "_lasts"},
            $sformatf("last flags=%0d want %0d", n_lasts, v.exp_lasts));
        chk(stray == 0, {tag, "_grant_idle"},
            $sformatf("grants without valid=%0d want 0", stray));
        if (v.exp_tiles > 0 && v.en_from > 4 || v.exp_tiles > 0 && v.en_len == 0)
            chk(first_cyc == ((v.stall == 0) ? 4 : v.stall + 1), {tag, "_first_lat"},
                $sformatf("first tile at cycle %0d want %0d", first_cyc,
                          (v.stall == 0) ? 4 : v.stall + 1));
        if (v.exp_tiles == 0)
            chk(done_cyc == 1, {tag, "_zero_done"},
                $sformatf("done at cycle %0d want 1", done_cyc));
        if (v.stall > 0)
            chk(stall_viol == 0, {tag, "_stall"},
                $sformatf("tiles during stall=%0d want 0", stall_viol));
        if (v.en_len > 0)
            chk(en_viol == 0, {tag, "_disabled"},
                $sformatf("outputs while disabled=%0d want 0", en_viol));
`ifdef MMTILED_TILE_SCHED_STATS_EN
        exp_cnt = v.exp_tiles;
`else
        exp_cnt = 0;
`endif
        chk(tile_count_out == 32'(exp_cnt), {tag, "_count"},
            $sformatf("tile_count=%0d want %0d", tile_count_out, exp_cnt));
    endtask

    initial begin
        //        sz  tl  rq       tiles lasts stall en_from en_len poke
        vecs[0] = '{64, 16, 4'b0001, 64, 16,  0,  0, 0, 1'b0};
        vecs[1] = '{40, 16, 4'b0001, 27,  9,  0,  0, 0, 1'b0};
        vecs[2] = '{32, 16, 4'b1111,  8,  4,  0,  0, 0, 1'b0};
        vecs[3] = '{48, 16, 4'b0101, 27,  9,  0,  0, 0, 1'b0};
        vecs[4] = '{20,  8, 4'b1010, 27,  9,  0,  0, 0, 1'b0};
        vecs[5] = '{16, 16, 4'b0010,  1,  1,  0,  0, 0, 1'b0};
        vecs[6] = '{ 0, 16, 4'b0001,  0,  0,  0,  0, 0, 1'b0};
        vecs[7] = '{16,  0, 4'b0001,  0,  0,  0,  0, 0, 1'b0};
        vecs[8] = '{64, 16, 4'b0001, 64, 16, 40,  0, 0, 1'b1};
        vecs[9] = '{64, 16, 4'b0011, 64, 16,  0, 20, 5, 1'b0};

        for (int n = 0; n < 10; n++) begin
            do_reset();
            run_job(vecs[n], $sformatf("v%0d", n));
        end

        // Reset in the middle of generation aborts the job; a new start replays it.
        do_reset();
        size_n_in    = 32'd64;
        tile_size_in = 32'd16;
        req_in       = 4'b0001;
        start_in     = 1'b1;
        step();
        start_in = 1'b0;
        repeat (9) step();
        chk(busy_out == 1'b1, "midrst_busy_before", $sformatf("busy=%0b want 1", busy_out));
        rst_in = 1'b1;
        step();
        check_reset_outputs("midrst_outputs");
        rst_in = 1'b0;
        run_job(vecs[0], "replay");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want job completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmtiled_tile_scheduler.md
# mmtiled_tile_scheduler

Sequences the tile loop nest (ii, jj, kk) of the tiled matrix-multiply compute unit and shares the resulting tile jobs among several tile engines. On a start pulse it walks all tile triples for an N×N problem in row-major order (ii outer, kk inner) and buffers them in an internal FIFO. A round-robin arbiter hands one tile per grant to requesting engines. It sits between the WED/configuration path and the per-engine matrix read-command generators in the mmtiled global CU.

## Interface
- NUM_REQ, 4: number of tile-engine requesters (2..8)
- FIFO_DEPTH, 16: tile-job buffer depth (power of two)
- clock  in  1  single clock, all logic posedge
- rst_in  in  1  synchronous, active-high reset
- enabled_in  in  1  global enable; low freezes FSM, FIFO and arbiter
- start_in  in  1  one-cycle start pulse; ignored unless FSM in IDLE
- size_n_in  in  32  matrix dimension in elements, sampled on accepted start
- tile_size_in  in  32  tile edge in elements, sampled on accepted start
- req_in  in  NUM_REQ  per-engine request level; one tile popped per grant
- grant_out  out  NUM_REQ  one-hot grant, valid with tile_valid_out
- tile_valid_out  out  1  tile triple valid, one cycle per grant
- tile_ii_out / tile_jj_out / tile_kk_out  out  32 each  tile origin indices
- tile_last_out  out  1  triple is last kk for its (ii,jj); C tile complete
- busy_out  out  1  high from accepted start until DONE
- done_out  out  1  one-cycle pulse at job end
- tile_count_out  out  32  granted tile count (see Configuration)

## Operation
- FSM states: IDLE, SETUP, GEN, DRAIN, DONE.
- IDLE: on start_in && enabled_in, latch size_n and tile_size. If either is 0 go to DONE, otherwise go to SETUP.
- SETUP: clear ii/jj/kk to 0, clear the FIFO count, go to GEN.
- GEN: each enabled cycle with registered FIFO count < FIFO_DEPTH, push {ii,jj,kk,last}.
  - Advance kk += tile_size. On kk wrap, set kk=0 and jj += tile_size. On jj wrap, set jj=0 and ii += tile_size.
  - After pushing the triple where ii, jj and kk are all at their final value, go to DRAIN.
- DRAIN: when the FIFO is empty and no output is pending, go to DONE.
- DONE: assert done_out for one cycle, then return to IDLE.
- Wrap and last rule: next = cur + tile_size, computed in 33 bits. Wrap when next ≥ size_n. tile_last_out = (kk + tile_size ≥ size_n).
- Non-multiple sizes: indices stop at the largest multiple of tile_size below size_n. Example: size_n=40, tile=16 gives 0, 16, 32.
- Arbiter grant condition: FIFO non-empty && |req_in && enabled_in.
  - Grant the first requester at or after the rr pointer, pop the FIFO head, register the outputs.
  - Set the pointer to granted index+1, modulo NUM_REQ.
- Push while full: blocked, even if a pop occurs in the same cycle, because the full check uses the registered count. Simultaneous push and pop with count < FIFO_DEPTH leaves the count unchanged.
- enabled_in low: no state change, no push, no grant; tile_valid_out=0 and grant_out=0.
- start_in outside IDLE is ignored.
- Reset mid-operation aborts the job and empties the FIFO; no done_out is issued.

## Timing
- Reset values of all outputs: tile_valid_out, tile_last_out, busy_out and done_out = 0; grant_out = 0; all index outputs = 0; tile_count_out = 0.
- FSM resets to IDLE and the rr pointer to 0.
- Start to first FIFO push: start accepted at cycle t, SETUP at t+1, first push at t+2.
- Request to grant: with the FIFO non-empty, req sampled at cycle t gives grant_out/tile_valid_out at t+1.
  - The first tile is grantable at t+3 and appears on the outputs at t+4.
- Throughput: one push and one grant per cycle, sustained.
- busy_out rises at t+1 and falls in the same cycle done_out pulses.
- Zero-size job: done_out pulses at t+1.

## Configuration
- MMTILED_TILE_SCHED_STATS_EN defined: tile_count_out increments on every grant, saturates at 2^32-1, and clears on accepted start.
- Undefined: the counter is not built and tile_count_out is tied to 0.

## Test plan
- size_n=64, tile=16, req_in=4'b0001 held: 64 tiles in order (0,0,0), (0,0,16), …, (48,48,48).
  - tile_last_out on every kk=48 (16 times); done_out once; tile_count_out=64 with STATS_EN.
- size_n=40, tile=16, one requester: 27 tiles with indices in {0,16,32}; last on kk=32.
- req_in=4'b1111 held, size_n=32, tile=16: grants cycle 0001, 0010, 0100, 1000, then 0001 for the 8 tiles.
- req_in=0 for 40 cycles after start: generator stalls with count=16 and GEN held. Releasing req_in delivers all 64 tiles in order with no loss or duplication.
- size_n=0: done_out one cycle after start; no tile_valid_out. A start pulse during GEN is ignored.
- rst_in asserted mid-GEN: next cycle all outputs are at reset values and the FSM is in IDLE. A new start then replays the job from (0,0,0).
